exe_muldiv_ctrl: RTL and testbench

- Sequencer for a shared iterative multiply/divide resource beside the EXE-stage ALU; the ALU handles only single-cycle operations.
- Accepts one operation from EXE and runs radix-2 shift-add multiply or restoring divide.
- Holds the pipeline through a stall output and keeps the HI/LO results until the next accepted operation.

---
 rtl/exe_muldiv_ctrl_if.sv | 33 +++
 rtl/exe_muldiv_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_exe_muldiv_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/exe_muldiv_ctrl_if.sv
// exe_muldiv_ctrl_if
//   Handshake/result bundle between the EXE stage and the iterative
//   multiply/divide sequencer.
//   Ports (signals):
//     start, op[1:0], a, b         EXE -> sequencer request and operands
//     ready, stall, busy, done     sequencer status back to the pipeline
//     hi, lo, dbz                  results and divide-by-zero flag
//   Modports: master (EXE side), slave (sequencer side).
interface exe_muldiv_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             stall;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             dbz;

   modport master (
      output start, op, a, b,
      input  ready, stall, busy, done, hi, lo, dbz
   );

   modport slave (
      input  start, op, a, b,
      output ready, stall, busy, done, hi, lo, dbz
   );
endinterface

// File: rtl/exe_muldiv_ctrl.sv
// exe_muldiv_ctrl
//   Sequencer for a shared iterative multiply/divide unit beside the EXE ALU.
//   Radix-2 shift-add multiply and restoring divide, one iteration per cycle,
//   with a final sign-fix cycle for the signed operations.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   exe_muldiv_ctrl_if.slave: start/op/a/b in; ready/stall/busy/
//           done/hi/lo/dbz out.
//   op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
//   Optional build macro MULDIV_EARLY_OUT_EN: zero-operand multiplies and
//   divides with |a| < |b| skip the iteration loop (results unchanged).
module exe_muldiv_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input logic              clk,
   input logic              rst,
   exe_muldiv_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         op_q;
   logic               sa_q;
   logic               sb_q;
   logic               zdiv_q;
   logic [WIDTH-1:0]   opnd_q;    // multiplicand or divisor magnitude
   logic [2*WIDTH:0]   acc;       // mul: {carry,hi,lo}; div: {0,rem,quo}
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               ready_q;
   logic               busy_q;
   logic               done_q;
   logic               dbz_q;

   logic               accept;
   logic               is_div;
   logic               is_sgn;
   logic               b_zero;
   logic               early;
   logic               skip;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [2*WIDTH:0]   acc_init;
   logic [WIDTH-1:0]   opnd_init;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH:0]   mul_next;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH+1:0]   div_diff;
   logic [2*WIDTH:0]   div_next;

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   // ---------------- accept-side operand preparation ----------------
   always_comb begin
      accept = bus.start & ((state == S_IDLE) | (state == S_DONE));
      is_div = bus.op[1];
      is_sgn = bus.op[0];
      a_abs  = (is_sgn & bus.a[WIDTH-1]) ? (-bus.a) : bus.a;
      b_abs  = (is_sgn & bus.b[WIDTH-1]) ? (-bus.b) : bus.b;
      b_zero = (bus.b == '0);
`ifdef MULDIV_EARLY_OUT_EN
      early  = is_div ? (!b_zero && (a_abs < b_abs))
                      : ((bus.a == '0) || (bus.b == '0));
`else
      early  = 1'b0;
`endif
      skip      = (is_div & b_zero) | early;
      opnd_init = is_div ? b_abs : a_abs;

      // Divide by zero preloads the fixed result so FIX just passes it on
      if (is_div & b_zero)
         acc_init = {1'b0, bus.a, {WIDTH{1'b1}}};
      else if (early & is_div)
         acc_init = {1'b0, a_abs, {WIDTH{1'b0}}};
      else if (early)
         acc_init = '0;
      else
         acc_init = {1'b0, {WIDTH{1'b0}}, is_div ? a_abs : b_abs};
   end

   // ---------------- one iteration of each algorithm ----------------
   always_comb begin
      mul_sum  = acc[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, opnd_q})
                        : acc[2*WIDTH:WIDTH];
      mul_next = {1'b0, mul_sum, acc[WIDTH-1:1]};

      // {rem,quo} << 1, then trial subtract; sign of the extended diff
      // tells whether the divisor fits
      rem_sh   = acc[2*WIDTH-1:WIDTH-1];
      div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
      if (div_diff[WIDTH+1])
         div_next = {1'b0, rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         div_next = {1'b0, div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   // ---------------- sign fix applied on the FIX cycle ----------------
   always_comb begin
      prod     = acc[2*WIDTH-1:0];
      prod_fix = (sa_q ^ sb_q) ? (-prod) : prod;
      quo_fix  = (sa_q ^ sb_q) ? (-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      rem_fix  = sa_q ? (-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
      fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = prod_fix[WIDTH-1:0];
      if (op_q[1]) begin
         if (zdiv_q) begin
            fix_hi = acc[2*WIDTH-1:WIDTH];
            fix_lo = acc[WIDTH-1:0];
         end else begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
         end
      end
   end

   // ---------------- sequencer ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         zdiv_q  <= 1'b0;
         opnd_q  <= '0;
         acc     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  op_q    <= bus.op;
                  sa_q    <= is_sgn & bus.a[WIDTH-1];
                  sb_q    <= is_sgn & bus.b[WIDTH-1];
                  zdiv_q  <= is_div & b_zero;
                  opnd_q  <= opnd_init;
                  acc     <= acc_init;
                  cnt     <= '0;
                  dbz_q   <= 1'b0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= skip ? S_FIX : S_CALC;
               end else begin
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            S_CALC: begin
               acc <= op_q[1] ? div_next : mul_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST)
                  state <= S_FIX;
            end
            S_FIX: begin
               hi_q   <= fix_hi;
               lo_q   <= fix_lo;
               dbz_q  <= zdiv_q;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= S_DONE;
            end
            default: begin
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.stall = (bus.start & ready_q) | busy_q;
   assign bus.done  = done_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.dbz   = dbz_q;

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// tb_exe_muldiv_ctrl
//   Directed testbench for exe_muldiv_ctrl (WIDTH=32): reset, multiply and
//   divide results, latency, stall shape, divide by zero, start-while-busy,
//   back-to-back accept in DONE, signed overflow, reset abort and the
//   zero/small-operand cases affected by MULDIV_EARLY_OUT_EN.
module tb_exe_muldiv_ctrl;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   lat;
   int   ndone;
   int   first_done;
   logic stall_ok;

   exe_muldiv_ctrl_if #(.WIDTH(32)) bus ();

   exe_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one op, return the cycle index of done (start cycle = 0).
   // stall_ok collects the stall shape: exp_s0 in cycle 0, 1 while waiting,
   // 0 in the DONE cycle.
   task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic exp_s0, output int l);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = va;
      bus.b     = vb;
      #1;
      stall_ok = (bus.stall === exp_s0);
      tick();
      bus.start = 1'b0;
      l = 1;
      while (bus.done !== 1'b1 && l < 100) begin
         if (bus.stall !== 1'b1) stall_ok = 1'b0;
         tick();
         l++;
      end
      if (bus.stall !== 1'b0) stall_ok = 1'b0;
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_ready", {63'd0, bus.ready}, 64'd1);
      chk("rst_busy",  {63'd0, bus.busy},  64'd0);
      chk("rst_done",  {63'd0, bus.done},  64'd0);
      chk("rst_stall", {63'd0, bus.stall}, 64'd0);
      chk("rst_hilo",  {bus.hi, bus.lo},   64'd0);
      chk("rst_dbz",   {63'd0, bus.dbz},   64'd0);

      // MULTU max*max
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat);
      chk("multu_lat",   64'(lat), 64'd34);
      chk("multu_hilo",  {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
      chk("multu_stall", {63'd0, stall_ok}, 64'd1);
      chk("multu_dbz",   {63'd0, bus.dbz},  64'd0);
      tick();
      chk("idle_ready", {63'd0, bus.ready}, 64'd1);
      tick();
      tick();
      chk("idle_hold",  {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

      // MULT -3 * 7
      run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b1, lat);
      chk("mult_lat",  64'(lat), 64'd34);
      chk("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      tick();

      // DIV -7 / 2
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1, lat);
      chk("div_neg_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      tick();

      // DIVU 100 / 0
      run_op(2'b10, 32'd100, 32'd0, 1'b1, lat);
      chk("dbz_lat",   64'(lat), 64'd2);
      chk("dbz_flag",  {63'd0, bus.dbz}, 64'd1);
      chk("dbz_hilo",  {bus.hi, bus.lo}, {32'd100, 32'hFFFF_FFFF});
      chk("dbz_stall", {63'd0, stall_ok}, 64'd1);
      tick();
      chk("dbz_hold",  {63'd0, bus.dbz}, 64'd1);

      // DIVU 100 / 7
      run_op(2'b10, 32'd100, 32'd7, 1'b1, lat);
      chk("divu_lat",  64'(lat), 64'd34);
      chk("divu_dbz",  {63'd0, bus.dbz}, 64'd0);
      chk("divu_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});
      tick();

      // second start while busy is ignored
      bus.start = 1'b1;
      bus.op    = 2'b10;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      tick();
      bus.start = 1'b0;
      ndone      = 0;
      first_done = 0;
      for (int c = 1; c < 80; c++) begin
         if (c == 5) begin
            bus.start = 1'b1;
            bus.op    = 2'b00;
            bus.a     = 32'd3;
            bus.b     = 32'd3;
         end
         if (c == 6) bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            ndone++;
            if (first_done == 0) first_done = c;
         end
         tick();
      end
      chk("busy_ndone", 64'(ndone), 64'd1);
      chk("busy_lat",   64'(first_done), 64'd34);
      chk("busy_hilo",  {bus.hi, bus.lo}, {32'd2, 32'd14});

      // start held in DONE is accepted
      run_op(2'b10, 32'd100, 32'd7, 1'b1, lat);
      chk("b2b_first_lat", 64'(lat), 64'd34);
      run_op(2'b00, 32'd5, 32'd6, 1'b0, lat);
      chk("b2b_lat",   64'(lat), 64'd34);
      chk("b2b_hilo",  {bus.hi, bus.lo}, 64'd30);
      chk("b2b_stall", {63'd0, stall_ok}, 64'd1);
      tick();

      // signed overflow
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
      chk("ovf_hilo", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});
      chk("ovf_dbz",  {63'd0, bus.dbz}, 64'd0);
      tick();

      // reset at CALC cycle 10 of a MULTU
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.a     = 32'h1234_5678;
      bus.b     = 32'h9ABC_DEF0;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      chk("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_ready", {63'd0, bus.ready}, 64'd1);
      chk("abort_busy",  {63'd0, bus.busy},  64'd0);
      chk("abort_hilo",  {bus.hi, bus.lo},   64'd0);
      ndone = 0;
      for (int c = 0; c < 50; c++) begin
         if (bus.done === 1'b1) ndone++;
         tick();
      end
      chk("abort_nodone", 64'(ndone), 64'd0);

      // zero-operand multiply and small-dividend divides
      run_op(2'b00, 32'd0, 32'd5, 1'b1, lat);
`ifdef MULDIV_EARLY_OUT_EN
      chk("mz_lat", 64'(lat), 64'd2);
`else
      chk("mz_lat", 64'(lat), 64'd34);
`endif
      chk("mz_hilo", {bus.hi, bus.lo}, 64'd0);
      tick();
      run_op(2'b10, 32'd5, 32'd100, 1'b1, lat);
`ifdef MULDIV_EARLY_OUT_EN
      chk("dsmall_lat", 64'(lat), 64'd2);
`else
      chk("dsmall_lat", 64'(lat), 64'd34);
`endif
      chk("dsmall_hilo", {bus.hi, bus.lo}, {32'd5, 32'd0});
      tick();
      run_op(2'b11, 32'hFFFF_FFFB, 32'd100, 1'b1, lat);
      chk("dsneg_hilo", {bus.hi, bus.lo}, {32'hFFFF_FFFB, 32'd0});
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
